// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
//  ttt_game_ctrl : button conditioning, cursor, turn FSM and win/draw detection
//  Revision 1.0
// ============================================================================
module ttt_game_ctrl #(
   parameter int DEB_CYCLES = 250000,
   parameter int CNT_W      = 18
) (
   input  logic        clk25M,
   input  logic        rst,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        mark,
   output logic [17:0] board,
   output logic [3:0]  cursor,
   output logic        turn,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic [7:0]  win_line,
   output logic        place_ok,
   output logic        place_rej
);

   localparam int               C_NBTN    = 5;
   localparam int               C_MARK    = 0;
   localparam int               C_UP      = 1;
   localparam int               C_DOWN    = 2;
   localparam int               C_LEFT    = 3;
   localparam int               C_RIGHT   = 4;
   localparam logic [CNT_W-1:0] C_DEB_MAX = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      S_PLAY  = 2'd0,
      S_CHECK = 2'd1,
      S_OVER  = 2'd2
   } state_t;

   logic [C_NBTN-1:0] btn;
   logic [C_NBTN-1:0] sync1_q, sync2_q, deb_q, deb_dly_q;
   logic [CNT_W-1:0]  cnt_q [C_NBTN];
   logic [C_NBTN-1:0] cmd, sel;

   state_t      state_q;
   logic [17:0] board_q;
   logic [3:0]  cursor_q, cursor_d;
   logic        turn_q, game_over_q, place_ok_q, place_rej_q;
   logic [1:0]  winner_q;
   logic [7:0]  win_line_q;

   logic [7:0]  line_hit;
   logic [1:0]  line_sym;
   logic        board_full;

   assign btn = {right, left, down, up, mark};

   // Counter runs only while a level change is pending; any bounce back clears it.
   always_ff @(posedge clk25M or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         for (int b = 0; b < C_NBTN; b++) cnt_q[b] <= '0;
      end else begin
         sync1_q   <= btn;
         sync2_q   <= sync1_q;
         deb_dly_q <= deb_q;
         for (int b = 0; b < C_NBTN; b++) begin
            if (sync2_q[b] == deb_q[b]) begin
               cnt_q[b] <= '0;
            end else if (cnt_q[b] == C_DEB_MAX) begin
               deb_q[b] <= sync2_q[b];
               cnt_q[b] <= '0;
            end else begin
               cnt_q[b] <= cnt_q[b] + 1'b1;
            end
         end
      end
   end

   assign cmd = deb_q & ~deb_dly_q;
   assign sel = cmd & (~cmd + 5'd1);   // lowest set bit wins: mark first

   function automatic logic [3:0] f_move(input logic [3:0] c, input logic [C_NBTN-1:0] s);
      logic [1:0] row, col;
      case (c)
         4'd0: {row, col} = {2'd0, 2'd0};
         4'd1: {row, col} = {2'd0, 2'd1};
         4'd2: {row, col} = {2'd0, 2'd2};
         4'd3: {row, col} = {2'd1, 2'd0};
         4'd5: {row, col} = {2'd1, 2'd2};
         4'd6: {row, col} = {2'd2, 2'd0};
         4'd7: {row, col} = {2'd2, 2'd1};
         4'd8: {row, col} = {2'd2, 2'd2};
         default: {row, col} = {2'd1, 2'd1};
      endcase
      if (s[C_UP])    row = (row == 2'd0) ? 2'd2 : row - 2'd1;
      if (s[C_DOWN])  row = (row == 2'd2) ? 2'd0 : row + 2'd1;
      if (s[C_LEFT])  col = (col == 2'd0) ? 2'd2 : col - 2'd1;
      if (s[C_RIGHT]) col = (col == 2'd2) ? 2'd0 : col + 2'd1;
      return {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
   endfunction

   assign cursor_d = f_move(cursor_q, sel);

   function automatic logic [11:0] f_line(input int l);
      case (l)
         0: return {4'd0, 4'd1, 4'd2};
         1: return {4'd3, 4'd4, 4'd5};
         2: return {4'd6, 4'd7, 4'd8};
         3: return {4'd0, 4'd3, 4'd6};
         4: return {4'd1, 4'd4, 4'd7};
         5: return {4'd2, 4'd5, 4'd8};
         6: return {4'd0, 4'd4, 4'd8};
         default: return {4'd2, 4'd4, 4'd6};
      endcase
   endfunction

   always_comb begin : p_eval
      logic [11:0] cells;
      logic [1:0]  a, b, c;
      line_hit   = '0;
      line_sym   = '0;
      board_full = 1'b1;
      cells      = '0;
      a = '0; b = '0; c = '0;
      for (int i = 0; i < 9; i++)
         if (board_q[2*i +: 2] == 2'b00) board_full = 1'b0;
      for (int l = 0; l < 8; l++) begin
         cells = f_line(l);
         a = board_q[{cells[11:8], 1'b0} +: 2];
         b = board_q[{cells[7:4],  1'b0} +: 2];
         c = board_q[{cells[3:0],  1'b0} +: 2];
         if (a != 2'b00 && a == b && b == c) begin
            line_hit[l] = 1'b1;
            line_sym    = line_sym | a;
         end
      end
   end

   always_ff @(posedge clk25M or posedge rst) begin
      if (rst) begin
         state_q     <= S_PLAY;
         board_q     <= '0;
         cursor_q    <= 4'd4;
         turn_q      <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 2'b00;
         win_line_q  <= '0;
         place_ok_q  <= 1'b0;
         place_rej_q <= 1'b0;
      end else begin
         place_ok_q  <= 1'b0;
         place_rej_q <= 1'b0;
         case (state_q)
            S_PLAY: begin
               if (sel[C_MARK]) begin
                  if (board_q[{cursor_q, 1'b0} +: 2] == 2'b00) begin
                     board_q[{cursor_q, 1'b0} +: 2] <= turn_q ? 2'b10 : 2'b01;
                     place_ok_q <= 1'b1;
                     state_q    <= S_CHECK;
                  end else begin
                     place_rej_q <= 1'b1;
                  end
               end else if (|sel) begin
                  cursor_q <= cursor_d;
               end
            end
            S_CHECK: begin
               if (|line_hit) begin
                  winner_q    <= line_sym;
                  win_line_q  <= line_hit;
                  game_over_q <= 1'b1;
                  state_q     <= S_OVER;
               end else if (board_full) begin
                  winner_q    <= 2'b11;
                  game_over_q <= 1'b1;
                  state_q     <= S_OVER;
               end else begin
                  turn_q  <= ~turn_q;
                  state_q <= S_PLAY;
               end
            end
            S_OVER: begin
               if (sel[C_MARK]) begin
                  board_q     <= '0;
                  cursor_q    <= 4'd4;
                  turn_q      <= 1'b0;
                  winner_q    <= 2'b00;
                  win_line_q  <= '0;
                  game_over_q <= 1'b0;
                  state_q     <= S_PLAY;
               end
            end
            default: state_q <= S_PLAY;
         endcase
      end
   end

   assign board     = board_q;
   assign cursor    = cursor_q;
   assign turn      = turn_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign win_line  = win_line_q;
   assign place_ok  = place_ok_q;
   assign place_rej = place_rej_q;

endmodule
`default_nettype wire
